// File: rtl/cordic_pkg.sv
// cordic_pkg: shared angle table, gain constant and FSM types
// for the CORDIC engines. Angles are full-circle = 2^N units.
package cordic_pkg;

    localparam int CW    = 5;
    localparam int TAB_N = 24;

    // atan(2^-i) in 32-bit full-circle units, rounded
    localparam logic [31:0] ATAN_TAB [TAB_N] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
        32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051
    };

    // 1/K = 0.607252935 as a 32-bit unsigned fraction
    localparam logic [31:0] KINV32 = 32'h9B74_EDA8;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Rescale a 32-bit fraction/angle to w bits, round to nearest
    function automatic logic [31:0] round_to_w(input logic [31:0] v,
                                               input int w);
        logic [31:0] r;
        if (w >= 32) r = v;
        else         r = (v + (32'd1 << (31 - w))) >> (32 - w);
        return r;
    endfunction

    function automatic logic [31:0] atan_w(input int i, input int w);
        return round_to_w(ATAN_TAB[i[4:0]], w);
    endfunction

endpackage

// File: rtl/cordic_microrot.sv
// cordic_microrot: one combinational CORDIC micro-rotation.
// Shared by the iterative engine and the unrolled variant.
module cordic_microrot
    import cordic_pkg::*;
#(
    parameter int W = 18
) (
    input  logic [W-1:0]  x,
    input  logic [W-1:0]  y,
    input  logic [W-1:0]  z,
    input  logic [CW-1:0] sh,
    input  logic [W-1:0]  phi,
    input  logic          mode,
    output logic [W-1:0]  x_next,
    output logic [W-1:0]  y_next,
    output logic [W-1:0]  z_next
);

    logic [W-1:0] xs;
    logic [W-1:0] ys;
    logic         d;

    // d=1 rotates counter-clockwise; rotation drives z to 0, vectoring drives y to 0
    always_comb begin
        xs = $signed(x) >>> sh;
        ys = $signed(y) >>> sh;
        d  = (mode == MODE_ROT) ? ~z[W-1] : y[W-1];
        if (d) begin
            x_next = x - ys;
            y_next = y + xs;
            z_next = z - phi;
        end else begin
            x_next = x + ys;
            y_next = y - xs;
            z_next = z + phi;
        end
    end

endmodule

// File: rtl/cordic_iter_param.sv
// cordic_iter_param: iterative CORDIC, one micro-rotation per clock,
// valid/ready in and out. CORDIC_GAIN_COMP_EN adds a 1/K SCALE step.
module cordic_iter_param
    import cordic_pkg::*;
#(
    parameter int W    = 18,
    parameter int ITER = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [W-1:0] x_in,
    input  logic [W-1:0] y_in,
    input  logic [W-1:0] z_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] x_out,
    output logic [W-1:0] y_out,
    output logic [W-1:0] z_out,
    output logic         busy
);

    if (ITER < 4 || ITER > W - 1 || ITER > TAB_N) begin : g_bad_iter
        $fatal(1, "cordic_iter_param: ITER must be 4..min(W-1,24)");
    end

`ifdef CORDIC_GAIN_COMP_EN
    localparam state_t AFTER_RUN = SCALE;
    localparam logic [W-1:0] KINV = W'(round_to_w(KINV32, W));
    localparam int PW = 2 * W + 2;

    // v * 1/K, rounded to nearest, wrapped to W bits
    function automatic logic [W-1:0] gain(input logic [W-1:0] v);
        logic signed [PW-1:0] p;
        p = $signed({{(W + 2){v[W-1]}}, v})
          * $signed({{(W + 2){1'b0}}, KINV});
        p = p + PW'(1 << (W - 1));
        return W'(p >>> W);
    endfunction
`else
    localparam state_t AFTER_RUN = DONE;
`endif

    state_t        state;
    state_t        state_n;
    logic [W-1:0]  xr, yr, zr;
    logic [W-1:0]  xp, yp, zp;
    logic [W-1:0]  xn, yn, zn;
    logic [W-1:0]  phi;
    logic [CW-1:0] cnt;
    logic          md;
    logic          flip;
    logic          acc;
    logic          last;

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign acc       = in_valid && in_ready;
    assign last      = (cnt == CW'(ITER - 1));

    // fold operands into the converging half-plane by adding 180 deg
    always_comb begin
        flip = (mode == MODE_ROT) ? (z_in[W-1] ^ z_in[W-2]) : x_in[W-1];
        xp   = flip ? -x_in : x_in;
        yp   = flip ? -y_in : y_in;
        zp   = flip ? {~z_in[W-1], z_in[W-2:0]} : z_in;
    end

    // elementary angle for the current iteration
    always_comb begin
        phi = W'(atan_w(int'(cnt), W));
    end

    cordic_microrot #(.W(W)) u_rot (
        .x      (xr),
        .y      (yr),
        .z      (zr),
        .sh     (cnt),
        .phi    (phi),
        .mode   (md),
        .x_next (xn),
        .y_next (yn),
        .z_next (zn)
    );

    // next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (in_valid) state_n = RUN;
            RUN:     if (last) state_n = AFTER_RUN;
            SCALE:   state_n = DONE;
            DONE:    if (out_ready) state_n = in_valid ? RUN : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // working registers: load on accept, iterate while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xr  <= '0;
            yr  <= '0;
            zr  <= '0;
            md  <= MODE_ROT;
            cnt <= '0;
        end else if (acc) begin
            xr  <= xp;
            yr  <= yp;
            zr  <= zp;
            md  <= mode;
            cnt <= '0;
        end else if (state == RUN) begin
            xr  <= xn;
            yr  <= yn;
            zr  <= zn;
            cnt <= cnt + 1'b1;
        end
    end

    // result registers: loaded once per transaction, held across handshakes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_out <= '0;
            y_out <= '0;
            z_out <= '0;
`ifdef CORDIC_GAIN_COMP_EN
        end else if (state == SCALE) begin
            x_out <= gain(xr);
            y_out <= gain(yr);
            z_out <= zr;
`else
        end else if (state == RUN && last) begin
            x_out <= xn;
            y_out <= yn;
            z_out <= zn;
`endif
        end
    end

endmodule

// File: tb/tb_cordic_iter_param.sv
// tb_cordic_iter_param: random + directed stimulus against a
// bit-true arithmetic CORDIC model kept in the bench.
`timescale 1ns/1ps
module tb_cordic_iter_param;

    localparam int W    = 18;
    localparam int ITER = 16;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT = ITER + 2;
    localparam int LIM = 1 << (W - 2);
`else
    localparam int LAT = ITER + 1;
    localparam int LIM = 1 << (W - 3);
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         mode = 1'b0;
    logic [W-1:0] x_in = '0;
    logic [W-1:0] y_in = '0;
    logic [W-1:0] z_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] x_out, y_out, z_out;
    logic         busy;

    cordic_iter_param #(.W(W), .ITER(ITER)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed { int x; int y; int z; int acc; } exp_t;
    exp_t q[$];

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int rdy_mode = 0;
    int last_x = 0, last_y = 0, last_z = 0;
    int phi [ITER];
    int kinv = 0;
    bit seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic check_tol(input string nm, input int act, input int exp, input int tol);
        n_chk++;
        if (act >= exp - tol && act <= exp + tol) n_pass++;
        else $display("FAIL %s: got %0d want %0d +-%0d", nm, act, exp, tol);
    endtask

    task automatic note_fail(input string nm);
        n_chk++;
        $display("FAIL %s: got timeout want completion (cycle %0d)", nm, cyc);
    endtask

    function automatic int wrap(input longint v);
        longint m;
        m = v & ((64'sd1 <<< W) - 1);
        if (m >= (64'sd1 <<< (W - 1))) m = m - (64'sd1 <<< W);
        return int'(m);
    endfunction

    function automatic int sx(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    // CORDIC on plain integers: half-turn fold, ITER rotations, optional 1/K
    function automatic void model(input int x0, input int y0, input int z0,
                                  input bit m, output int xo, output int yo,
                                  output int zo);
        int x, y, z, xn, yn, h;
        bit flip, d;
        x = x0; y = y0; z = z0;
        h = 1 << (W - 2);
        flip = m ? (x < 0) : (z >= h || z < -h);
        if (flip) begin
            x = wrap(-longint'(x));
            y = wrap(-longint'(y));
            z = wrap(longint'(z) + 2 * h);
        end
        for (int i = 0; i < ITER; i++) begin
            d  = m ? (y < 0) : (z >= 0);
            xn = d ? wrap(longint'(x) - (y >>> i)) : wrap(longint'(x) + (y >>> i));
            yn = d ? wrap(longint'(y) + (x >>> i)) : wrap(longint'(y) - (x >>> i));
            z  = d ? wrap(longint'(z) - phi[i]) : wrap(longint'(z) + phi[i]);
            x  = xn;
            y  = yn;
        end
`ifdef CORDIC_GAIN_COMP_EN
        x = wrap((longint'(x) * kinv + (64'sd1 <<< (W - 1))) >>> W);
        y = wrap((longint'(y) * kinv + (64'sd1 <<< (W - 1))) >>> W);
`endif
        xo = x; yo = y; zo = z;
    endfunction

    task automatic send(input int x, input int y, input int z, input bit m,
                        output int waited);
        exp_t e;
        int xo, yo, zo;
        model(x, y, z, m, xo, yo, zo);
        e.x = xo; e.y = yo; e.z = zo;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        mode = m;
        x_in = W'(x);
        y_in = W'(y);
        z_in = W'(z);
        #1;
        while (!in_ready) begin
            if (waited >= 300) begin
                note_fail("accept_timeout");
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
            waited++;
        end
        e.acc = cyc + 1;
        @(posedge clk);
        q.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) note_fail("drain_timeout");
        @(negedge clk);
    endtask

    // consumer ready pattern: 0 low, 1 high, else random
    initial begin
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // per-cycle compare against the expected-result queue
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                seen = 1'b0;
                continue;
            end
            check("busy", busy, q.size() != 0);
            check("in_ready", in_ready,
                  (q.size() == 0) || (out_valid && out_ready));
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out_valid", out_valid, 0);
                end else begin
                    if (!seen) begin
                        check("latency", cyc + 1 - q[0].acc, LAT);
                        seen = 1'b1;
                        last_x = sx(x_out);
                        last_y = sx(y_out);
                        last_z = sx(z_out);
                    end
                    check("x_out", sx(x_out), q[0].x);
                    check("y_out", sx(y_out), q[0].y);
                    check("z_out", sx(z_out), q[0].z);
                    if (out_ready) begin
                        void'(q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, n, a, b, c;
        real t;
        t = 1.0;
        for (int i = 0; i < ITER; i++) begin
            phi[i] = $rtoi($floor($atan(t) * (2.0 ** W) / (2.0 * 3.14159265358979) + 0.5));
            t = t / 2.0;
        end
        kinv = $rtoi($floor(0.607252935 * (2.0 ** W) + 0.5));

        check("model_phi0", phi[0], 32768);
`ifdef CORDIC_GAIN_COMP_EN
        model(65536, 0, 65536, 1'b0, a, b, c);
        check_tol("model_gc_y", b, 65536, 6);
`else
        model(30000, 40000, 0, 1'b1, a, b, c);
        check_tol("model_vec_z", c, 38688, 4);
`endif

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_x_out", x_out, 0);
        check("rst_y_out", y_out, 0);
        check("rst_z_out", z_out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        rdy_mode = 1;

`ifdef CORDIC_GAIN_COMP_EN
        send(65536, 0, 65536, 1'b0, w); drain();
        check_tol("gc_rot90_x", last_x, 0, 4);
        check_tol("gc_rot90_y", last_y, 65536, 6);
`else
        send(39797, 0, 32768, 1'b0, w); drain();
        check_tol("rot45_x", last_x, 46341, 4);
        check_tol("rot45_y", last_y, 46341, 4);
        check_tol("rot45_z", last_z, 0, 2);

        send(30000, 40000, 0, 1'b1, w); drain();
        check_tol("vec_x", last_x, 82338, 8);
        check_tol("vec_y", last_y, 0, 4);
        check_tol("vec_z", last_z, 38688, 4);

        send(39797, 0, -131072, 1'b0, w); drain();
        check_tol("rot180_x", last_x, -65536, 4);
        check_tol("rot180_y", last_y, 0, 4);

        send(-30000, 0, 0, 1'b1, w); drain();
        check_tol("vec_neg_absz", last_z < 0 ? -last_z : last_z, 131072, 2);
`endif

        // back-pressure, then release together with a new request
        rdy_mode = 0;
        send(30000, 40000, 0, 1'b1, w);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) note_fail("bp_out_valid_timeout");
        repeat (5) @(negedge clk);
        #1;
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        rdy_mode = 1;
        send(-20000, 15000, 70000, 1'b0, w);
        check("b2b_accept_wait", w, 0);
        drain();

        // reset in the middle of RUN
        send(12345, -23456, 40000, 1'b0, w);
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        q.delete();
        #1;
        check("midrst_x_out", x_out, 0);
        check("midrst_y_out", y_out, 0);
        check("midrst_z_out", z_out, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (ITER + 4) @(negedge clk);
        send(25000, 10000, -50000, 1'b1, w);
        drain();

        // random traffic with random consumer stalls
        rdy_mode = 2;
        for (int k = 0; k < 60; k++) begin
            send(int'($urandom_range(0, 2 * LIM - 2)) - (LIM - 1),
                 int'($urandom_range(0, 2 * LIM - 2)) - (LIM - 1),
                 int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1)),
                 1'($urandom_range(0, 1)), w);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rdy_mode = 1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
